// File: rtl/arp_pkg.sv
// Shared ARP constants and the reply-sender state encoding.
// Also used by the receive path (arp_recv) so both ends agree on the header layout.
package arp_pkg;

   localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
   localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IP   = 16'h0800;
   localparam logic [7:0]  ARP_HLEN       = 8'd6;
   localparam logic [7:0]  ARP_PLEN       = 8'd4;
   localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
   localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

   // Ethernet header (14) plus ARP payload (28), before padding
   localparam int ARP_HDR_BYTES = 42;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } arp_state_t;

endpackage

// File: rtl/arp_frame_mux.sv
// Combinational byte selector: maps a frame byte index onto the captured
// address fields of an ARP reply, returning the pad byte past the header.
module arp_frame_mux
   import arp_pkg::*;
#(
   parameter logic [7:0] PAD_BYTE = 8'h00
) (
   input  logic [7:0]  byte_idx,
   input  logic [47:0] local_mac,
   input  logic [31:0] local_ip,
   input  logic [47:0] remote_mac,
   input  logic [31:0] remote_ip,
   output logic [7:0]  byte_out
);

   logic [ARP_HDR_BYTES*8-1:0] hdr;
   logic [5:0]                 rev_idx;

   // Byte 0 sits in the most significant slot so the frame reads big-endian
   assign hdr = {remote_mac, local_mac, ETH_TYPE_ARP,
                 ARP_HTYPE_ETH, ARP_PTYPE_IP, ARP_HLEN, ARP_PLEN, ARP_OP_REPLY,
                 local_mac, local_ip, remote_mac, remote_ip};

   always_comb begin
      byte_out = PAD_BYTE;
      rev_idx  = '0;
      if (byte_idx < 8'(ARP_HDR_BYTES)) begin
         rev_idx  = 6'(ARP_HDR_BYTES - 1) - byte_idx[5:0];
         byte_out = hdr[{rev_idx, 3'b000} +: 8];
      end
   end

endmodule

// File: rtl/arp_send.sv
// ARP reply sender: captures a reply request from the receive path and
// streams a padded Ethernet ARP reply frame byte-wise over AXI-stream.
module arp_send
   import arp_pkg::*;
#(
   parameter int         FRAME_LEN  = 60,
   parameter logic [7:0] PAD_BYTE   = 8'h00,
   parameter int         IFG_CYCLES = 12
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [47:0] local_mac_addr,
   input  logic [31:0] local_ip_addr,
   input  logic        arp_reply_in,
   input  logic [31:0] remote_ip_addr_in,
   input  logic [47:0] remote_mac_addr_in,
   output logic        reply_ready_out,
   output logic        arp_reply_ack_out,
   output logic [7:0]  axis_tdata_out,
   output logic        axis_tvalid_out,
   output logic        axis_tlast_out,
   input  logic        axis_tready_in
);

   localparam logic [7:0]  LAST_IDX = 8'(FRAME_LEN - 1);
   localparam logic [15:0] GAP_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

   arp_state_t  state, state_next;
   logic [7:0]  byte_cnt;
   logic [15:0] gap_cnt;
   logic        ack_q;
   logic        capture, xfer, last_byte, gap_done;
   logic [47:0] cap_local_mac, cap_remote_mac;
   logic [31:0] cap_local_ip, cap_remote_ip;
   logic [7:0]  mux_byte;

   // Next-state decode; a request is only taken while idle, otherwise the
   // producer keeps holding its level until we come back around
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      xfer       = (state == SEND) && axis_tready_in;
      last_byte  = (byte_cnt == LAST_IDX);
      gap_done   = (gap_cnt == GAP_LAST);
      case (state)
         IDLE: begin
            if (arp_reply_in) begin
               capture    = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            if (xfer && last_byte) begin
               state_next = (IFG_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: begin
            if (gap_done) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         byte_cnt <= 8'd0;
         gap_cnt  <= 16'd0;
         ack_q    <= 1'b0;
      end else begin
         state <= state_next;
         ack_q <= capture;
         if (capture) begin
            byte_cnt <= 8'd0;
         end else if (xfer) begin
            byte_cnt <= last_byte ? 8'd0 : byte_cnt + 8'd1;
         end
         if (state != GAP) begin
            gap_cnt <= 16'd0;
         end else begin
            gap_cnt <= gap_cnt + 16'd1;
         end
      end
   end

   // Address snapshot, so later input changes cannot corrupt the frame in flight
   always_ff @(posedge clk) begin
      if (reset_n && capture) begin
         cap_local_mac  <= local_mac_addr;
         cap_local_ip   <= local_ip_addr;
         cap_remote_mac <= remote_mac_addr_in;
         cap_remote_ip  <= remote_ip_addr_in;
      end
   end

   arp_frame_mux #(
      .PAD_BYTE(PAD_BYTE)
   ) u_frame_mux (
      .byte_idx  (byte_cnt),
      .local_mac (cap_local_mac),
      .local_ip  (cap_local_ip),
      .remote_mac(cap_remote_mac),
      .remote_ip (cap_remote_ip),
      .byte_out  (mux_byte)
   );

   assign reply_ready_out   = reset_n && (state == IDLE);
   assign arp_reply_ack_out = ack_q;
   assign axis_tvalid_out   = (state == SEND);
   assign axis_tlast_out    = (state == SEND) && last_byte;
   assign axis_tdata_out    = (state == SEND) ? mux_byte : 8'h00;

endmodule

// File: tb/tb_arp_send.sv
// Directed bench for arp_send: a 60-byte/12-gap instance for the main
// scenarios and a 42-byte/no-gap instance for the short-frame corner.
module tb_arp_send;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [47:0] local_mac, remote_mac;
   logic [31:0] local_ip, remote_ip;
   logic        arp_req, tready;
   logic        ready, ack, tvalid, tlast;
   logic [7:0]  tdata;
   logic        s_req, s_tready;
   logic        s_ready, s_ack, s_tvalid, s_tlast;
   logic [7:0]  s_tdata;

   int err_cnt = 0;
   int chk_cnt = 0;
   int rx_n, rx_last, lat;
   logic [7:0] rx [0:255];

   // Hand-assembled reply for MAC 00:0A:35:01:02:03 / 192.168.1.10 answering
   // MAC 11:22:33:44:55:66 / 192.168.1.20
   logic [7:0] exp_hdr [0:41] = '{
      8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
      8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03,
      8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
      8'h00, 8'h0A, 8'h35, 8'h01, 8'h02, 8'h03,
      8'hC0, 8'hA8, 8'h01, 8'h0A,
      8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
      8'hC0, 8'hA8, 8'h01, 8'h14};

   always #5 clk = ~clk;

   arp_send #(.FRAME_LEN(60), .PAD_BYTE(8'h00), .IFG_CYCLES(12)) dut (
      .clk(clk), .reset_n(reset_n),
      .local_mac_addr(local_mac), .local_ip_addr(local_ip),
      .arp_reply_in(arp_req), .remote_ip_addr_in(remote_ip), .remote_mac_addr_in(remote_mac),
      .reply_ready_out(ready), .arp_reply_ack_out(ack),
      .axis_tdata_out(tdata), .axis_tvalid_out(tvalid), .axis_tlast_out(tlast),
      .axis_tready_in(tready));

   arp_send #(.FRAME_LEN(42), .PAD_BYTE(8'h00), .IFG_CYCLES(0)) dut_short (
      .clk(clk), .reset_n(reset_n),
      .local_mac_addr(local_mac), .local_ip_addr(local_ip),
      .arp_reply_in(s_req), .remote_ip_addr_in(remote_ip), .remote_mac_addr_in(remote_mac),
      .reply_ready_out(s_ready), .arp_reply_ack_out(s_ack),
      .axis_tdata_out(s_tdata), .axis_tvalid_out(s_tvalid), .axis_tlast_out(s_tlast),
      .axis_tready_in(s_tready));

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      chk_cnt++;
      if (actual !== expected) begin
         err_cnt++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [7:0] expByte(input int i);
      if (i < 42) return exp_hdr[i];
      return 8'h00;
   endfunction

   // All sampling and driving happens 1 time unit after the rising edge
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Raise the request and wait (bounded) for the ack; lat counts edges taken
   task automatic applyStimulus(input logic hold, output int lat_out);
      arp_req = 1'b1;
      lat_out = 0;
      do begin
         stepCycle();
         lat_out++;
      end while (!ack && lat_out < 40);
      checkOutput("ack_seen", ack, 1'b1);
      checkOutput("tvalid_with_ack", tvalid, 1'b1);
      if (!hold) arp_req = 1'b0;
   endtask

   // Collect one frame from the main instance; mode 1 applies backpressure
   task automatic recvFrame(input int mode);
      int  c = 0;
      int  stall_left = 0;
      int  acks = 0;
      bit  stall_done = 1'b0;
      bit  vdrop = 1'b0;
      bit  done = 1'b0;
      rx_n = 0;
      rx_last = -1;
      while (!done && c < 400) begin
         if (c > 0 && ack) acks++;
         if (!tvalid) vdrop = 1'b1;
         if (mode == 0) begin
            tready = 1'b1;
         end else begin
            if (rx_n == 30 && !stall_done) begin
               stall_left = 10;
               stall_done = 1'b1;
            end
            if (stall_left > 0) begin
               tready = 1'b0;
               stall_left--;
            end else begin
               tready = (c % 2 == 0);
            end
         end
         if (tvalid && !tready) begin
            checkOutput($sformatf("stall_data%0d", rx_n), tdata, expByte(rx_n));
            checkOutput($sformatf("stall_last%0d", rx_n), tlast, (rx_n == 59));
         end
         if (tvalid && tready) begin
            rx[rx_n] = tdata;
            if (tlast && rx_last < 0) rx_last = rx_n;
            if (tlast) done = 1'b1;
            rx_n++;
         end
         stepCycle();
         c++;
      end
      tready = 1'b1;
      checkOutput("frame_done", done, 1'b1);
      checkOutput("nbytes", rx_n, 60);
      checkOutput("tlast_idx", rx_last, 59);
      checkOutput("tvalid_held", vdrop, 1'b0);
      checkOutput("extra_ack", acks, 0);
      checkOutput("tvalid_after_last", tvalid, 1'b0);
      for (int i = 0; i < 60 && i < rx_n; i++) begin
         checkOutput($sformatf("byte%0d", i), rx[i], expByte(i));
      end
   endtask

   initial begin
      int n;
      local_mac  = 48'h000A35010203;
      local_ip   = 32'hC0A8010A;
      remote_mac = 48'h112233445566;
      remote_ip  = 32'hC0A80114;
      arp_req = 1'b0;
      tready = 1'b1;
      s_req = 1'b0;
      s_tready = 1'b1;
      reset_n = 1'b0;

      repeat (3) stepCycle();
      checkOutput("rst_ready", ready, 1'b0);
      checkOutput("rst_ack", ack, 1'b0);
      checkOutput("rst_tvalid", tvalid, 1'b0);
      checkOutput("rst_tlast", tlast, 1'b0);
      checkOutput("rst_tdata", tdata, 8'h00);
      reset_n = 1'b1;
      stepCycle();
      checkOutput("idle_ready", ready, 1'b1);
      checkOutput("s_idle_ready", s_ready, 1'b1);

      $display("[TB] scenario 1: basic reply");
      applyStimulus(1'b0, lat);
      checkOutput("capture_latency", lat, 1);
      checkOutput("ready_in_send", ready, 1'b0);
      recvFrame(0);

      $display("[TB] scenario 2: backpressure");
      applyStimulus(1'b0, lat);
      recvFrame(1);

      $display("[TB] scenario 3: back-to-back with held request");
      applyStimulus(1'b1, lat);
      recvFrame(0);
      checkOutput("gap_ready", ready, 1'b0);
      n = 0;
      while (!tvalid && n < 40) begin
         stepCycle();
         n++;
         if (n == 11) checkOutput("gap_ready_last", ready, 1'b0);
         if (n == 12) checkOutput("gap_idle_ready", ready, 1'b1);
      end
      checkOutput("ifg_latency", n, 13);
      checkOutput("ack_second", ack, 1'b1);
      arp_req = 1'b0;
      recvFrame(0);

      $display("[TB] scenario 4: input change after capture");
      applyStimulus(1'b0, lat);
      remote_ip = 32'h0A000001;
      recvFrame(0);
      remote_ip = 32'hC0A80114;

      $display("[TB] scenario 5: reset mid-frame");
      applyStimulus(1'b0, lat);
      tready = 1'b1;
      for (int c = 0; c < 20; c++) stepCycle();
      checkOutput("pre_reset_byte", tdata, expByte(20));
      reset_n = 1'b0;
      stepCycle();
      checkOutput("mid_rst_tvalid", tvalid, 1'b0);
      checkOutput("mid_rst_tlast", tlast, 1'b0);
      checkOutput("mid_rst_ack", ack, 1'b0);
      checkOutput("mid_rst_ready", ready, 1'b0);
      reset_n = 1'b1;
      stepCycle();
      checkOutput("post_rst_ready", ready, 1'b1);
      checkOutput("post_rst_tvalid", tvalid, 1'b0);
      applyStimulus(1'b0, lat);
      checkOutput("post_rst_latency", lat, 1);
      recvFrame(0);

      $display("[TB] scenario 6: 42-byte frame, no gap");
      s_req = 1'b1;
      n = 0;
      do begin
         stepCycle();
         n++;
      end while (!s_ack && n < 40);
      checkOutput("s_ack", s_ack, 1'b1);
      checkOutput("s_latency", n, 1);
      s_req = 1'b0;
      rx_n = 0;
      rx_last = -1;
      n = 0;
      while (n < 200) begin
         if (s_tvalid && s_tready) begin
            rx[rx_n] = s_tdata;
            if (s_tlast && rx_last < 0) rx_last = rx_n;
            rx_n++;
            if (s_tlast) begin
               stepCycle();
               break;
            end
         end
         stepCycle();
         n++;
      end
      checkOutput("s_nbytes", rx_n, 42);
      checkOutput("s_tlast_idx", rx_last, 41);
      checkOutput("s_ready_after", s_ready, 1'b1);
      checkOutput("s_tvalid_after", s_tvalid, 1'b0);
      for (int i = 0; i < 42 && i < rx_n; i++) begin
         checkOutput($sformatf("s_byte%0d", i), rx[i], expByte(i));
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
